// File: rtl/chunk_addsub.sv
// Multi-cycle adder/subtractor: operands are latched on start and summed CHUNK bits
// per clock through a ripple carry register; results are published only on completion.
module chunk_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(NCH - 1);
  localparam logic [WIDTH-1:0] CH_MASK  = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, part_q, part_nxt;
  logic             carry_q;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   sum;
  logic             msb_cin;
  logic             accept;
  logic             last;
  int               base;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make update order matter.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every variable driven in an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (idx == LAST_IDX);

  // One CHUNK-wide slice of the ripple sum; the carry into the top bit is recovered
  // from the sum bit so overflow works for any CHUNK, including 1.
  always_comb begin
    base     = int'(idx) * CHUNK;
    a_chunk  = CHUNK'(a_q >> base);
    b_chunk  = CHUNK'(b_q >> base);
    sum      = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);
    msb_cin  = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum[CHUNK-1];
    part_nxt = (part_q & ~(CH_MASK << base)) | (WIDTH'(sum[CHUNK-1:0]) << base);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      out     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub | cin;
      idx     <= '0;
    end else if (state == RUN) begin
      part_q  <= part_nxt;
      carry_q <= sum[CHUNK];
      idx     <= last ? '0 : idx + 1'b1;
      if (last) begin
        out  <= part_nxt;
        cout <= sum[CHUNK];
        ovf  <= msb_cin ^ sum[CHUNK];
        zero <= (part_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_chunk_addsub.sv
// Self-checking bench for chunk_addsub: directed table, protocol corner cases and
// random operations on 32/8, 16/4 and 8/8 instances against an arithmetic model.
module tb_chunk_addsub;

  typedef struct packed {
    logic [31:0] out;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct packed {
    logic [31:0] out;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        busy;
    logic        done;
  } obs_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          sub;
    bit          cin;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        st [3];
  logic        sb [3];
  logic        ci [3];
  logic [31:0] av [3];
  logic [31:0] bv [3];

  logic [31:0] out0;
  logic [15:0] out1;
  logic [7:0]  out2;
  logic        cout0, ovf0, zero0, busy0, done0;
  logic        cout1, ovf1, zero1, busy1, done1;
  logic        cout2, ovf2, zero2, busy2, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chunk_addsub #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .start(st[0]), .sub(sb[0]), .cin(ci[0]),
    .a(av[0]), .b(bv[0]), .out(out0), .cout(cout0), .ovf(ovf0),
    .zero(zero0), .busy(busy0), .done(done0)
  );

  chunk_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .start(st[1]), .sub(sb[1]), .cin(ci[1]),
    .a(av[1][15:0]), .b(bv[1][15:0]), .out(out1), .cout(cout1), .ovf(ovf1),
    .zero(zero1), .busy(busy1), .done(done1)
  );

  chunk_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(st[2]), .sub(sb[2]), .cin(ci[2]),
    .a(av[2][7:0]), .b(bv[2][7:0]), .out(out2), .cout(cout2), .ovf(ovf2),
    .zero(zero2), .busy(busy2), .done(done2)
  );

  function automatic int width_of(input int inst);
    return (inst == 0) ? 32 : (inst == 1) ? 16 : 8;
  endfunction

  function automatic int nch_of(input int inst);
    return (inst == 2) ? 1 : 4;
  endfunction

  function automatic obs_t obs(input int inst);
    obs_t o;
    case (inst)
      0:       o = '{out: out0, cout: cout0, ovf: ovf0, zero: zero0, busy: busy0, done: done0};
      1:       o = '{out: {16'h0, out1}, cout: cout1, ovf: ovf1, zero: zero1, busy: busy1, done: done1};
      default: o = '{out: {24'h0, out2}, cout: cout2, ovf: ovf2, zero: zero2, busy: busy2, done: done2};
    endcase
    return o;
  endfunction

  // Reference: plain unsigned and signed arithmetic on w-bit values.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input bit sub, input bit cin);
    res_t   r;
    longint mask, half, ua, ub, sa, sbb, u, s;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
    sbb  = (ub >= half) ? ub - (longint'(1) << w) : ub;
    if (sub) begin
      u      = ua - ub;
      s      = sa - sbb;
      r.cout = (ua >= ub);
    end else begin
      u      = ua + ub + longint'(cin);
      s      = sa + sbb + longint'(cin);
      r.cout = ((u >> w) & 1) != 0;
    end
    r.out  = 32'(u & mask);
    r.ovf  = (s >= half) || (s < -half);
    r.zero = (r.out == 32'h0);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int inst, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic sub, input logic cin);
    st[inst] = s;
    av[inst] = a;
    bv[inst] = b;
    sb[inst] = sub;
    ci[inst] = cin;
  endtask

  task automatic wait_done(input int inst, output int lat);
    lat = 0;
    while (!obs(inst).done && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic check_res(input string name, input int inst, input res_t exp);
    obs_t o;
    o = obs(inst);
    check({name, "_out"},  64'(o.out),  64'(exp.out));
    check({name, "_cout"}, 64'(o.cout), 64'(exp.cout));
    check({name, "_ovf"},  64'(o.ovf),  64'(exp.ovf));
    check({name, "_zero"}, 64'(o.zero), 64'(exp.zero));
  endtask

  // Full operation with inputs and start scrambled throughout RUN.
  task automatic run_op(input string name, input int inst, input logic [31:0] a,
                        input logic [31:0] b, input bit sub, input bit cin, input res_t exp);
    obs_t prev, o;
    int   lat, bcnt;
    bit   held;
    prev = obs(inst);
    set_in(inst, 1'b1, a, b, sub, cin);
    step();
    lat  = 0;
    bcnt = 0;
    held = 1'b1;
    for (int k = 0; k < 20; k++) begin
      o = obs(inst);
      if (o.done) break;
      if (o.busy) bcnt++;
      if (o.out !== prev.out || o.cout !== prev.cout || o.ovf !== prev.ovf || o.zero !== prev.zero)
        held = 1'b0;
      set_in(inst, 1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      step();
      lat++;
    end
    st[inst] = 1'b0;
    check({name, "_latency"}, 64'(lat),  64'(nch_of(inst)));
    check({name, "_busy"},    64'(bcnt), 64'(nch_of(inst)));
    check({name, "_held"},    64'(held), 64'd1);
    check_res(name, inst, exp);
  endtask

  vec_t tbl [8];

  initial begin
    obs_t o;
    int   lat;
    bit   quiet;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, '{32'h80000001, 1'b0, 1'b1, 1'b0}};
    tbl[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}};
    tbl[3] = '{32'h00000007, 32'h00000005, 1'b1, 1'b0, '{32'h00000002, 1'b1, 1'b0, 1'b0}};
    tbl[4] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, '{32'h00000007, 1'b1, 1'b0, 1'b0}};
    tbl[5] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, '{32'h00000000, 1'b0, 1'b0, 1'b1}};
    tbl[6] = '{32'h12345678, 32'h0000FF88, 1'b0, 1'b0, '{32'h12355600, 1'b0, 1'b0, 1'b0}};
    tbl[7] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};

    step();
    step();
    for (int i = 0; i < 3; i++) check($sformatf("reset_state%0d", i), 64'(obs(i)), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), 0, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, tbl[i].exp);

    run_op("w16", 1, 32'h8000, 32'h8000, 1'b0, 1'b0, '{32'h0000, 1'b1, 1'b1, 1'b1});
    run_op("w8_ovf", 2, 32'h7F, 32'h01, 1'b0, 1'b0, '{32'h80, 1'b0, 1'b1, 1'b0});
    run_op("w8_wrap", 2, 32'hFF, 32'h01, 1'b0, 1'b0, '{32'h00, 1'b1, 1'b0, 1'b1});

    // Start held through DONE: second operation must follow with no IDLE cycle.
    set_in(0, 1'b1, 32'h00000100, 32'h000000FF, 1'b0, 1'b0);
    step();
    set_in(0, 1'b1, 32'h00000010, 32'h00000020, 1'b1, 1'b0);
    wait_done(0, lat);
    check("b2b_first_latency", 64'(lat), 64'd4);
    check_res("b2b_first", 0, model(32, 32'h100, 32'hFF, 1'b0, 1'b0));
    step();
    check("b2b_no_idle_busy", 64'(obs(0).busy), 64'd1);
    st[0] = 1'b0;
    wait_done(0, lat);
    check("b2b_second_latency", 64'(lat), 64'd4);
    check_res("b2b_second", 0, model(32, 32'h10, 32'h20, 1'b1, 1'b0));
    step();

    // Reset on the second RUN edge aborts the operation without a done pulse.
    set_in(0, 1'b1, 32'h01020304, 32'h0A0B0C0D, 1'b0, 1'b1);
    step();
    st[0] = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("abort_outputs", 64'(obs(0)), 64'h0);
    rst = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      o = obs(0);
      if (o.done || o.busy || o.out != 32'h0) quiet = 1'b0;
    end
    check("abort_quiet", 64'(quiet), 64'd1);
    run_op("after_abort", 0, 32'd3, 32'd4, 1'b0, 1'b0, '{32'd7, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < 200; i++) begin
      int          inst;
      logic [31:0] ra, rb;
      bit          rs, rc;
      inst = $urandom_range(0, 2);
      ra   = $urandom;
      rb   = (i % 10 == 0) ? ra : $urandom;
      rs   = 1'($urandom);
      rc   = 1'($urandom);
      run_op($sformatf("rnd%0d", i), inst, ra, rb, rs, rc, model(width_of(inst), ra, rb, rs, rc));
      if ($urandom_range(0, 3) == 0) begin
        step();
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chunk_addsub.md
CHUNK_ADDSUB -- requirements
Module: chunk_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CHUNK, default 8, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK; NCH = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 start  input  1  request to begin an operation; sampled only when not busy.
REQ-006 sub  input  1  0 = add, 1 = subtract; latched at accepted start.
REQ-007 cin  input  1  carry-in for add; ignored when sub=1; latched at accepted start.
REQ-008 a  input  WIDTH  operand A; latched at accepted start.
REQ-009 b  input  WIDTH  operand B; latched at accepted start.
REQ-010 out  output  WIDTH  registered result.
REQ-011 cout  output  1  registered carry out of MSB; for subtract, 1 = no borrow.
REQ-012 ovf  output  1  registered two's-complement signed overflow.
REQ-013 zero  output  1  registered, 1 when out == 0.
REQ-014 busy  output  1  high while an operation is in progress.
REQ-015 done  output  1  single-cycle completion pulse.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE.
REQ-017 Start acceptance: the rising edge on which start=1 and state is IDLE or DONE SHALL latch a, sub ? ~b : b, carry = sub ? 1 : cin; clear the chunk index to 0; and enter RUN.
REQ-018 In RUN, each edge SHALL add chunk i of the latched A and B plus the stored carry, write CHUNK result bits into the partial register at [i*CHUNK +: CHUNK], update the stored carry, and increment i.
REQ-019 On the edge processing chunk NCH-1, the FSM SHALL enter DONE and load out, cout, ovf and zero from the final partial result and carry.
REQ-020 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-021 Latency: for a start accepted at edge E0, done SHALL be high for exactly the cycle after edge E(NCH), i.e. NCH clock edges after acceptance.
REQ-022 busy SHALL be 1 exactly while the state is RUN; done SHALL be 1 exactly while the state is DONE.
REQ-023 From DONE, the next edge SHALL go to RUN if start=1, otherwise to IDLE; back-to-back operations therefore have NCH+1 cycles of throughput.
REQ-024 start while in RUN SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-025 Inputs a, b, sub and cin changing during RUN SHALL NOT affect the result.
REQ-026 out, cout, ovf and zero SHALL hold their values from the last completion until the next completion, including through IDLE and subsequent RUN cycles.
REQ-027 Partial chunk results SHALL never be visible on out.
REQ-028 With NCH=1 the block SHALL complete in one RUN edge, with the same protocol.

Reset
REQ-029 rst=1 at an edge SHALL force state to IDLE, with out=0, cout=0, ovf=0, zero=0, busy=0, done=0, chunk index 0 and stored carry 0.
REQ-030 rst SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse and no result update.
REQ-031 After rst deasserts, the first start SHALL be accepted normally on the next edge.

Verification (WIDTH=32, CHUNK=8 unless noted)
REQ-032 Add a=0xFFFFFFFF, b=0x00000001, cin=0 -> done exactly 4 edges after acceptance; out=0x00000000, cout=1, ovf=0, zero=1; busy high for 4 cycles.
REQ-033 Add a=0x7FFFFFFF, b=0x00000001, cin=1 -> out=0x80000001, cout=0, ovf=1, zero=0.
REQ-034 Subtract a=5, b=7 -> out=0xFFFFFFFE, cout=0, ovf=0; then subtract a=7, b=5 -> out=0x00000002, cout=1.
REQ-035 Start pulsed with new operands during RUN, a, b and sub toggled mid-RUN -> ignored; the original result is unchanged. Start held high through DONE -> second operation accepted with no IDLE cycle.
REQ-036 rst asserted on the 2nd RUN edge of an operation -> no done pulse; all outputs 0 next cycle; the following add 3+4 yields out=7.
REQ-037 Instance WIDTH=16, CHUNK=4: 0x8000 + 0x8000 -> out=0x0000, cout=1, ovf=1, zero=1, done 4 edges after acceptance.
